// File: rtl/wb_dest_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a req/ready/rvalid data-memory sequencer.
// Optional load-use hazard detection is enabled by defining LOAD_USE_DETECT_EN.
module wb_dest_pipe #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ex_reg_wr,
  input  logic [AW-1:0] ex_dst,
  input  logic          ex_mem_rd,
  input  logic          ex_mem_wr,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  output logic          dm_req,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_ready,
  input  logic          dm_rvalid,
  input  logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] MEM_RegDstAddr,
  output logic          MEM_RegWr,
  output logic [DW-1:0] MEM_Data,
  output logic [AW-1:0] WB_RegDstAddr,
  output logic          WB_RegWr,
  output logic [DW-1:0] WB_Data,
  output logic          pipe_stall,
  output logic          load_use_stall
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_reg_wr_q, mem_reg_wr_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_dst_q, mem_dst_d;
  logic [DW-1:0] mem_result_q, mem_result_d;
  logic [DW-1:0] mem_sdata_q, mem_sdata_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          wb_reg_wr_q, wb_reg_wr_d;
  logic [AW-1:0] wb_dst_q, wb_dst_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          dm_req_q, dm_req_d;
  logic          dm_we_q, dm_we_d;
  logic [DW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic          stall;
  logic          mem_op_cap;

  always_comb begin
    stall        = (state_q == REQ) || (state_q == RESP);
    mem_valid_d  = mem_valid_q;
    mem_reg_wr_d = mem_reg_wr_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_dst_d    = mem_dst_q;
    mem_result_d = mem_result_q;
    mem_sdata_d  = mem_sdata_q;
    if (!stall) begin
      mem_valid_d  = ex_valid;
      mem_reg_wr_d = ex_valid & ex_reg_wr;
      mem_rd_d     = ex_valid & ex_mem_rd;
      mem_wr_d     = ex_valid & ex_mem_wr;
      mem_dst_d    = ex_dst;
      mem_result_d = ex_result;
      mem_sdata_d  = ex_store_data;
    end
    mem_op_cap = !stall && ex_valid && (ex_mem_rd || ex_mem_wr);

    state_d     = state_q;
    load_data_d = load_data_q;
    unique case (state_q)
      IDLE: if (mem_op_cap) state_d = REQ;
      REQ:  if (dm_ready) state_d = mem_rd_q ? RESP : DONE;
      RESP: begin
        if (dm_rvalid) begin
          load_data_d = dm_rdata;
          state_d     = DONE;
        end
      end
      DONE: state_d = mem_op_cap ? REQ : IDLE;
      default: state_d = IDLE;
    endcase

    // Request outputs are registered, so they are computed from the next MEM contents.
    dm_req_d   = (state_d == REQ);
    dm_we_d    = dm_req_d ? mem_wr_d : 1'b0;
    dm_addr_d  = dm_req_d ? mem_result_d : '0;
    dm_wdata_d = dm_req_d ? mem_sdata_d : '0;

    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    if (stall) begin
      wb_reg_wr_d = 1'b0;
    end else begin
      wb_reg_wr_d = mem_valid_q & mem_reg_wr_q & (mem_dst_q != '0);
      wb_dst_d    = mem_dst_q;
      wb_data_d   = mem_rd_q ? load_data_q : mem_result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_valid_q  <= 1'b0;
      mem_reg_wr_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_dst_q    <= '0;
      mem_result_q <= '0;
      mem_sdata_q  <= '0;
      load_data_q  <= '0;
      wb_reg_wr_q  <= 1'b0;
      wb_dst_q     <= '0;
      wb_data_q    <= '0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_reg_wr_q <= mem_reg_wr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_dst_q    <= mem_dst_d;
      mem_result_q <= mem_result_d;
      mem_sdata_q  <= mem_sdata_d;
      load_data_q  <= load_data_d;
      wb_reg_wr_q  <= wb_reg_wr_d;
      wb_dst_q     <= wb_dst_d;
      wb_data_q    <= wb_data_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  assign dm_req         = dm_req_q;
  assign dm_we          = dm_we_q;
  assign dm_addr        = dm_addr_q;
  assign dm_wdata       = dm_wdata_q;
  assign MEM_RegDstAddr = mem_dst_q;
  assign MEM_RegWr      = mem_valid_q & mem_reg_wr_q;
  assign MEM_Data       = mem_result_q;
  assign WB_RegDstAddr  = wb_dst_q;
  assign WB_RegWr       = wb_reg_wr_q;
  assign WB_Data        = wb_data_q;
  assign pipe_stall     = stall;

`ifdef LOAD_USE_DETECT_EN
  assign load_use_stall = ex_valid & ex_mem_rd & ex_reg_wr & (ex_dst != '0) &
                          ((ex_dst == id_rs) | (ex_dst == id_rt));
`else
  logic unused_id_srcs;
  assign unused_id_srcs = ^{id_rs, id_rt};
  assign load_use_stall = 1'b0;
`endif

endmodule
